div_nonrestoring_seq: RTL and testbench

- Sequential signed radix-2 non-restoring divider; the inverse operation of the team's booth array multiplier.
- Takes a 2*WB-bit product-width dividend and a WB-bit divisor, and returns a WB-bit quotient and a WB-bit remainder.
- Used to check or undo multiplier results, and as the datapath divide unit.
- Iterative core, one quotient bit per enabled clock, with a start/done handshake.

---
 rtl/div_nonrestoring_seq.sv | 190 +++++++++++++++++++
 tb/tb_div_nonrestoring_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_nonrestoring_seq.sv
// Sequential signed radix-2 non-restoring divider.
// Divides a 2*WB-bit signed dividend by a WB-bit signed divisor, one quotient
// bit per enabled clock, and returns a quotient truncated toward zero
// (saturated when it leaves the WB-bit signed range) plus a remainder whose
// sign follows the dividend.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start_i; results of the last divide are held
// ITER  | one non-restoring step per enabled edge, 2*WB steps in total
// FIX   | restore the remainder, apply signs, saturate, pulse done_o

module div_nonrestoring_seq #(
    parameter int unsigned word_size = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     ce_i,
    input  logic                     start_i,
    input  logic [2*word_size-1:0]   dividend_i,
    input  logic [word_size-1:0]     divisor_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [word_size-1:0]     q_o,
    output logic [word_size-1:0]     r_o,
    output logic                     ovf_o,
    output logic                     dbz_o
);

    localparam int WB = word_size;
    localparam int DW = 2 * WB;          // dividend / magnitude quotient width
    localparam int PW = WB + 2;          // partial remainder width (signed)
    localparam int CW = $clog2(DW + 1);  // iteration counter width

    // Signed quotient limits, expressed at the DW+1 width of the signed quotient.
    localparam logic signed [DW:0] Q_MAX = {{(DW - WB + 2){1'b0}}, {(WB - 1){1'b1}}};
    localparam logic signed [DW:0] Q_MIN = {{(DW - WB + 2){1'b1}}, {(WB - 1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [DW-1:0]   dvd_q;     // dividend magnitude, shifted out MSB-first; quotient shifts in at the LSB
    logic [WB:0]     dsr_q;     // divisor magnitude; WB+1 bits so that -2^(WB-1) fits
    logic [PW-1:0]   prem_q;    // signed partial remainder
    logic            sq_q;
    logic            sr_q;
    logic            dz_q;
    logic            busy_q;
    logic            done_q;
    logic [WB-1:0]   q_q;
    logic [WB-1:0]   r_q;
    logic            ovf_q;
    logic            dbz_q;

    logic [DW-1:0]   dvd_abs;
    logic [WB:0]     dsr_ext;
    logic [WB:0]     dsr_abs;
    logic            dsr_zero;
    logic [PW-1:0]   dsr_px;
    logic [PW-1:0]   prem_sh;
    logic [PW-1:0]   prem_d;
    logic [DW-1:0]   dvd_d;
    logic [PW-1:0]   rem_mag;
    logic [PW-1:0]   rem_sgn;
    logic [DW:0]     q_sgn;
    logic [WB-1:0]   q_fix;
    logic            q_ovf;
    logic            accept;
    logic            unused_rem;

    // Operand magnitudes taken at the accept edge.
    always_comb begin
        dvd_abs  = dividend_i[DW-1] ? -dividend_i : dividend_i;
        dsr_ext  = {divisor_i[WB-1], divisor_i};
        dsr_abs  = dsr_ext[WB] ? -dsr_ext : dsr_ext;
        dsr_zero = (divisor_i == '0);
        // A start in the done_o cycle is dropped: that cycle still belongs to
        // the divide that just finished.
        accept   = start_i && !done_q;
    end

    // One non-restoring step: shift in the next dividend bit, then subtract the
    // divisor from a non-negative remainder or add it to a negative one.
    always_comb begin
        dsr_px  = {1'b0, dsr_q};
        prem_sh = {prem_q[PW-2:0], dvd_q[DW-1]};
        prem_d  = prem_q[PW-1] ? (prem_sh + dsr_px) : (prem_sh - dsr_px);
        dvd_d   = {dvd_q[DW-2:0], ~prem_d[PW-1]};
    end

    // Final correction: restore a negative remainder, apply signs, saturate.
    always_comb begin
        rem_mag = prem_q[PW-1] ? (prem_q + dsr_px) : prem_q;
        rem_sgn = sr_q ? -rem_mag : rem_mag;
        q_sgn   = sq_q ? -{1'b0, dvd_q} : {1'b0, dvd_q};
        q_fix   = q_sgn[WB-1:0];
        q_ovf   = 1'b0;
        if ($signed(q_sgn) > Q_MAX) begin
            q_fix = {1'b0, {(WB - 1){1'b1}}};
            q_ovf = 1'b1;
        end else if ($signed(q_sgn) < Q_MIN) begin
            q_fix = {1'b1, {(WB - 1){1'b0}}};
            q_ovf = 1'b1;
        end
    end

    // |remainder| < |divisor| <= 2^(WB-1), so the upper bits carry only sign.
    assign unused_rem = &{1'b0, rem_sgn[PW-1:WB]};

    // Control FSM and datapath registers; a disabled clock freezes everything.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            prem_q  <= '0;
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else if (ce_i) begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        dvd_q   <= dvd_abs;
                        dsr_q   <= dsr_abs;
                        sq_q    <= dividend_i[DW-1] ^ divisor_i[WB-1];
                        sr_q    <= dividend_i[DW-1];
                        prem_q  <= '0;
                        cnt_q   <= CW'(DW);
                        dz_q    <= dsr_zero;
                        busy_q  <= 1'b1;
                        ovf_q   <= 1'b0;
                        dbz_q   <= 1'b0;
                        state_q <= dsr_zero ? S_FIX : S_ITER;
                    end
                end
                S_ITER: begin
                    prem_q <= prem_d;
                    dvd_q  <= dvd_d;
                    cnt_q  <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (dz_q) begin
                        q_q   <= '0;
                        r_q   <= '0;
                        ovf_q <= 1'b0;
                        dbz_q <= 1'b1;
                    end else begin
                        q_q   <= q_fix;
                        r_q   <= rem_sgn[WB-1:0];
                        ovf_q <= q_ovf;
                        dbz_q <= 1'b0;
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign q_o    = q_q;
    assign r_o    = r_q;
    assign ovf_o  = ovf_q;
    assign dbz_o  = dbz_q;

endmodule

// File: tb/tb_div_nonrestoring_seq.sv
// Scoreboard bench for div_nonrestoring_seq (WB = 8). Stimulus pushes the
// expected result computed with integer arithmetic; a monitor pops it on
// each done_o pulse and compares values and latency.

module tb_div_nonrestoring_seq;

    logic        clk;
    logic        rst;
    logic        ce;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy_o;
    logic        done_o;
    logic [7:0]  q_o;
    logic [7:0]  r_o;
    logic        ovf_o;
    logic        dbz_o;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       ovf;
        logic       dbz;
        int         lat;
        int         acc;
    } exp_t;

    exp_t sb[$];
    int   n_total  = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   done_cnt = 0;
    logic done_prev = 1'b0;

    div_nonrestoring_seq #(.word_size(8)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .ce_i       (ce),
        .start_i    (start),
        .dividend_i (dividend),
        .divisor_i  (divisor),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .q_o        (q_o),
        .r_o        (r_o),
        .ovf_o      (ovf_o),
        .dbz_o      (dbz_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    // Reference: signed integer division truncates toward zero and the
    // remainder takes the dividend's sign.
    function automatic exp_t model(input logic [15:0] a, input logic [7:0] b);
        exp_t e;
        int   ai;
        int   bi;
        int   qi;
        int   ri;
        e.q = 8'h00; e.r = 8'h00; e.ovf = 1'b0; e.dbz = 1'b0; e.lat = 0; e.acc = 0;
        ai = int'($signed(a));
        bi = int'($signed(b));
        if (bi == 0) begin
            e.dbz = 1'b1;
            return e;
        end
        qi = ai / bi;
        ri = ai % bi;
        if (qi > 127) begin
            e.q = 8'h7F; e.ovf = 1'b1;
        end else if (qi < -128) begin
            e.q = 8'h80; e.ovf = 1'b1;
        end else begin
            e.q = qi[7:0];
        end
        e.r = ri[7:0];
        return e;
    endfunction

    // Monitor: one comparison set per done_o rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (done_o && !done_prev) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("q", {24'd0, q_o}, {24'd0, e.q});
                chk("r", {24'd0, r_o}, {24'd0, e.r});
                chk("ovf", {31'd0, ovf_o}, {31'd0, e.ovf});
                chk("dbz", {31'd0, dbz_o}, {31'd0, e.dbz});
                chk("latency", cyc - e.acc, e.lat);
            end
        end
        done_prev = done_o;
    end

    task automatic wait_idle();
        int n = 0;
        while ((busy_o || done_o) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_div(input logic [15:0] a, input logic [7:0] b,
                          input int stall_at, input int stall_len, input bit inject);
        exp_t e;
        wait_idle();
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_accept", {31'd0, busy_o}, 32'd1);
        e     = model(a, b);
        e.lat = (b == 8'h00) ? 1 : 17 + stall_len;
        e.acc = cyc;
        sb.push_back(e);
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        if (stall_len > 0) begin
            repeat (stall_at) begin @(posedge clk); #1; end
            ce = 1'b0;
            repeat (stall_len) begin @(posedge clk); #1; end
            ce = 1'b1;
        end
        if (inject) begin
            repeat (3) begin @(posedge clk); #1; end
            dividend = 16'h1234;
            divisor  = 8'h01;
            start    = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    initial begin
        int n;
        int dc;
        logic [15:0] ra;
        logic [7:0]  rb;
        logic [7:0]  rs;

        rst = 1'b1; ce = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (4) begin @(posedge clk); #1; end
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_q", {24'd0, q_o}, 32'd0);
        chk("rst_r", {24'd0, r_o}, 32'd0);
        chk("rst_ovf", {31'd0, ovf_o}, 32'd0);
        chk("rst_dbz", {31'd0, dbz_o}, 32'd0);
        rst = 1'b0;
        ce  = 1'b1;

        do_div(16'h05E8, 8'h12, 0, 0, 1'b0);
        do_div(16'hFA18, 8'h12, 0, 0, 1'b0);
        do_div(16'hFF9C, 8'h07, 0, 0, 1'b0);
        do_div(16'h0064, 8'hF9, 0, 0, 1'b0);
        do_div(16'h4000, 8'h01, 0, 0, 1'b0);
        do_div(16'h8000, 8'hFF, 0, 0, 1'b0);
        do_div(16'hC000, 8'h01, 0, 0, 1'b0);
        do_div(16'h0080, 8'h80, 0, 0, 1'b0);
        do_div(16'h1234, 8'h00, 0, 0, 1'b0);
        do_div(16'h8000, 8'h80, 0, 0, 1'b0);
        do_div(16'h7FFF, 8'h7F, 0, 0, 1'b0);
        do_div(16'h05E8, 8'h12, 6, 5, 1'b0);
        do_div(16'hFF9C, 8'h07, 0, 0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            rb = 8'($urandom);
            if (i % 8 == 7) rb = 8'h00;
            if ($urandom_range(1, 0) == 1) begin
                ra = 16'($urandom);
            end else begin
                rs = 8'($urandom);
                ra = {{8{rs[7]}}, rs} * {{8{rb[7]}}, rb} + 16'($urandom_range(3, 0));
            end
            do_div(ra, rb, 0, 0, 1'b0);
        end

        do_div(16'hFF9C, 8'h07, 0, 0, 1'b0);
        wait_idle();

        // Abort a divide with reset during iteration 6.
        dividend = 16'h05E8;
        divisor  = 8'h12;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy_o}, 32'd0);
        chk("abort_done", {31'd0, done_o}, 32'd0);
        chk("abort_q", {24'd0, q_o}, 32'd0);
        chk("abort_r", {24'd0, r_o}, 32'd0);
        chk("abort_ovf", {31'd0, ovf_o}, 32'd0);
        chk("abort_dbz", {31'd0, dbz_o}, 32'd0);
        dc = done_cnt;
        repeat (25) begin @(posedge clk); #1; end
        chk("no_done_after_abort", done_cnt, dc);

        do_div(16'h0064, 8'hF9, 0, 0, 1'b0);

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("scoreboard_drained", sb.size(), 32'd0);
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1, "watchdog");
    end

endmodule
